// File: rtl/bin2bcd_8bit.sv
// Sequential binary-to-BCD converter using iterative shift-add-3 (double-dabble),
// one input bit per clock, with a busy/done handshake toward the display stage.
module bin2bcd_8bit #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     sreg;
    logic [BCD_W-1:0]     digits;
    logic [CNT_W-1:0]     count;

    logic [BCD_W-1:0]     adj_c;
    logic [BCD_W-1:0]     next_digits_c;

    // One add-3 correction per digit, then the shift pulls the next binary MSB into the ones digit.
    always_comb begin
        adj_c = digits;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digits[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = digits[4*i +: 4] + 4'd3;
            end
        end
        next_digits_c = {adj_c[BCD_W-2:0], sreg[WIDTH-1]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sreg   <= '0;
            digits <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg   <= binary;
                        digits <= '0;
                        count  <= CNT_W'(WIDTH);
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg   <= {sreg[WIDTH-2:0], 1'b0};
                    digits <= next_digits_c;
                    count  <= count - CNT_W'(1);
                    // Last iteration: publish the freshly shifted digits directly.
                    if (count == CNT_W'(1)) begin
                        bcd   <= next_digits_c;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_8bit.sv
// Self-checking bench for bin2bcd_8bit: directed scenarios plus randomized
// conversions compared against a decimal-digit reference model.
module tb_bin2bcd_8bit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  binary;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    // Stand-in for the upstream counter_8bit used in the integration scenario.
    logic        use_cnt;
    logic        cnt_load;
    logic        cnt_en;
    logic [7:0]  cnt_init;
    logic [7:0]  cnt;
    wire  [7:0]  dut_bin;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    assign dut_bin = use_cnt ? cnt : binary;

    always @(posedge clock) begin
        if (cnt_load)    cnt <= cnt_init;
        else if (cnt_en) cnt <= cnt + 8'd1;
    end

    bin2bcd_8bit dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .binary (dut_bin),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
    );

    function automatic logic [11:0] model(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; binary = 8'd0;
        use_cnt = 1'b0; cnt_load = 1'b1; cnt_init = 8'd0; cnt_en = 1'b0;
        repeat (2) tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b bcd=%h want 0 0 000", busy, done, bcd);
        end
        reset = 1'b1;
        cnt_load = 1'b0;
        tick();
    endtask

    task automatic test_convert(input logic [7:0] v, input logic check_tail);
        binary = v; start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_accept v=%0d: got %b want 1", v, busy);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if (k < 8) begin
                if (done !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL conv_wait v=%0d cyc=%0d: got done=%b busy=%b want 0 1", v, k, done, busy);
                end
            end else if (done !== 1'b1 || busy !== 1'b0 || bcd !== model(int'(v))) begin
                miscompares++;
                $display("FAIL conv_done v=%0d: got done=%b busy=%b bcd=%h want 1 0 %h",
                         v, done, busy, bcd, model(int'(v)));
            end
        end
        if (check_tail) begin
            tick();
            vectors++;
            if (done !== 1'b0 || bcd !== model(int'(v))) begin
                miscompares++;
                $display("FAIL done_width v=%0d: got done=%b bcd=%h want 0 %h", v, done, bcd, model(int'(v)));
            end
        end
    endtask

    task automatic test_zero;
        test_convert(8'd0, 1'b0);
    endtask

    task automatic test_max;
        test_convert(8'd255, 1'b1);
    endtask

    task automatic test_back_to_back;
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            binary = 8'(i);
            tick();
            binary = 8'($urandom);
            for (int k = 1; k <= 8; k++) begin
                tick();
                vectors++;
                if (k < 8) begin
                    if (done !== 1'b0) begin
                        miscompares++;
                        $display("FAIL sweep_spacing v=%0d cyc=%0d: got done=%b want 0", i, k, done);
                    end
                end else if (done !== 1'b1 || bcd !== model(i)) begin
                    miscompares++;
                    $display("FAIL sweep_result v=%0d: got done=%b bcd=%h want 1 %h", i, done, bcd, model(i));
                end
            end
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_ignore_start;
        int extra;
        binary = 8'd42; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        binary = 8'd200; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 4; k <= 8; k++) tick();
        vectors++;
        if (done !== 1'b1 || bcd !== 12'h042) begin
            miscompares++;
            $display("FAIL ignore_result: got done=%b bcd=%h want 1 042", done, bcd);
        end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL ignore_no_extra: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_abort;
        int seen;
        binary = 8'd137; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
            miscompares++;
            $display("FAIL abort_immediate: got busy=%b done=%b bcd=%h want 0 0 000", busy, done, bcd);
        end
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0 || bcd !== 12'h000) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d pulses bcd=%h want 0 000", seen, bcd);
        end
        test_convert(8'd137, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] v;
        int lat;
        logic got;
        for (int n = 0; n < 40; n++) begin
            v = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) tick();
            binary = v; start = 1'b1;
            tick();
            start = 1'b0;
            binary = 8'($urandom);
            lat = 0; got = 1'b0;
            while (!got && lat < 20) begin
                tick();
                lat++;
                if (done === 1'b1) got = 1'b1;
            end
            vectors++;
            if (!got || lat != 8 || bcd !== model(int'(v))) begin
                miscompares++;
                $display("FAIL random v=%0d: got seen=%b lat=%0d bcd=%h want 1 8 %h",
                         v, got, lat, bcd, model(int'(v)));
            end
        end
    endtask

    task automatic test_integration;
        logic [11:0] exp;
        logic [7:0]  preload [2];
        preload[0] = 8'hE0;
        preload[1] = 8'hEF;
        use_cnt = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            cnt_en = 1'b0; cnt_init = preload[ph]; cnt_load = 1'b1;
            tick();
            cnt_load = 1'b0; cnt_en = 1'b1;
            for (int p = 0; p < 4; p++) begin
                exp = model(int'(cnt));
                start = 1'b1;
                tick();
                start = 1'b0;
                for (int k = 1; k <= 15; k++) begin
                    tick();
                    if (k == 8) begin
                        vectors++;
                        if (done !== 1'b1 || bcd !== exp) begin
                            miscompares++;
                            $display("FAIL integration ph=%0d p=%0d: got done=%b bcd=%h want 1 %h",
                                     ph, p, done, bcd, exp);
                        end
                    end
                end
            end
        end
        cnt_en = 1'b0;
        use_cnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        test_random();
        test_integration();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
